boid_frame_reader: RTL
======================

Name: boid_frame_reader

Overview:
- Display-side reader for the 1-bit boid framebuffer that the boid writer loop fills.
- Generates 640x480@60 VGA scan timing and issues one framebuffer read address per pixel.
- Maps the returned bit to 12-bit RGB with sync signals aligned to it, and pulses frame_end so the writer can clear and refill the buffer.

Parameters:
- FG_RGB, 12'hFFF, colour of a pixel whose framebuffer bit is 1
- BG_RGB, 12'h000, colour of a pixel whose framebuffer bit is 0
- CURSOR_RGB, 12'hF00, scary-cursor colour (optional feature only)
- CURSOR_SIZE, 4, cursor square side in pixels, 1..15
- ADDR_WIDTH, 19, framebuffer address width

Ports:
- clock  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous active-low reset
- pix_en  in  1  pixel-rate enable, one clock in every two
- read_addr  out  ADDR_WIDTH  framebuffer read address, registered
- read_data  in  1  framebuffer bit; valid one clock after read_addr changes
- scary_x  in  10  cursor x position, quasi-static
- scary_y  in  9  cursor y position, quasi-static
- hSync  out  1  horizontal sync, active low
- vSync  out  1  vertical sync, active low
- VGA_R  out  4  red
- VGA_G  out  4  green
- VGA_B  out  4  blue
- frame_end  out  1  one-clock pulse after the last active pixel

Behaviour:
Reset:
- resetn low forces h_cnt=0, v_cnt=0, read_addr=0, all pipeline stages cleared, hSync=1, vSync=1, RGB=0, frame_end=0.
- Release takes effect on the first pix_en after deassertion.
- Reset mid-frame restarts the scan at (0,0) with no partial-line artefacts.

Counters (advance only when pix_en=1):
- h_cnt: 0..799, wraps to 0.
- v_cnt: 0..524; increments when h_cnt wraps, and wraps to 0 after 524.
- Active region: h_cnt<640 and v_cnt<480.
- Horizontal timing: front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: front porch 480..489, sync 490..491, back porch 492..524.

Stage 0 (on pix_en):
- read_addr <= h_cnt + 640*v_cnt when active, else 0.
- Arithmetic is 19-bit unsigned; the maximum value 307199 fits.
- The multiply is built from shifts and adds: (v<<9)+(v<<7).
- Stage 0 also registers active0, hs0, vs0 and the coordinates.

Stage 1 (on pix_en):
- Samples read_data, which is valid because the RAM has 1-clock latency and pix_en is at most 1 in 2 clocks.
- Registers active1, hs1, vs1 and the coordinates.

Stage 2 (on pix_en), output registers:
- hSync and vSync take their stage-1 values.
- RGB = 0 when not active; otherwise FG_RGB if the bit is 1, else BG_RGB.

Latency:
- A pixel at counter (x,y) appears on the outputs 2 pix_en ticks after the counters hold (x,y).
- Syncs carry the same 2-tick delay, so the timing is preserved relative to the colour.

frame_end:
- Asserted for exactly one clock, on the clock where pix_en=1 and the counters move from (639,479) to (640,479).
- Never asserted while resetn is low.

Boundary rules:
- pix_en held low freezes all state and outputs.
- pix_en high on consecutive clocks is illegal, because the RAM latency is not guaranteed.

Optional Feature:
Macro SCARY_CURSOR_EN.
- Defined: stage 1 computes a cursor hit when scary_x <= x < scary_x+CURSOR_SIZE and scary_y <= y < scary_y+CURSOR_SIZE.
  - Comparisons are 11/10-bit with no wrap, so a cursor near the right or bottom edge is clipped.
  - An active pixel with a hit outputs CURSOR_RGB, overriding the boid bit when both apply.
  - scary_x and scary_y are sampled in stage 0 with the pixel.
- Undefined: the scary_x and scary_y ports exist but are ignored, and no cursor logic is built.

Test Plan:
- Reset, pix_en toggling for 2 frames -> hSync low for exactly 96 ticks per 800-tick line; vSync low for lines 490-491; frame period 420000 pix_en ticks.
- Framebuffer model with bit set only at address 6410 (x=10, y=10) -> RGB=FFF exactly at output tick 2 after counter (10,10); all other active pixels 000.
- Check read_addr at (639,479) -> 307199; at blanking (700,100) -> 0.
- frame_end -> one clock high once per frame, following the (639,479) tick; count over 3 frames = 3.
- Assert resetn low at (320,240) for 5 clocks -> outputs at reset values immediately (async); after release the first line starts at h_cnt=0, v_cnt=0.
- With SCARY_CURSOR_EN, scary=(638,100), CURSOR_SIZE=4 -> F00 only at x=638..639, y=100..103; with boid bit also set at (638,100) -> F00. Without the macro -> FFF.

Source files
------------

// File: rtl/boid_frame_reader.sv
// 640x480@60 VGA reader for the 1-bit boid framebuffer; pixel reaches RGB/sync 2 pix_en ticks after its counter tick.
// No backpressure: paced only by pix_en (max 1 in 2 clocks); SCARY_CURSOR_EN overlays a cursor square.
module boid_frame_reader #(
  parameter logic [11:0] FG_RGB      = 12'hFFF,
  parameter logic [11:0] BG_RGB      = 12'h000,
  parameter logic [11:0] CURSOR_RGB  = 12'hF00,
  parameter int          CURSOR_SIZE = 4,
  parameter int          ADDR_WIDTH  = 19
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pix_en,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_data,
  input  logic [9:0]            scary_x,
  input  logic [8:0]            scary_y,
  output logic                  hSync,
  output logic                  vSync,
  output logic [3:0]            VGA_R,
  output logic [3:0]            VGA_G,
  output logic [3:0]            VGA_B,
  output logic                  frame_end
);

  logic [9:0] h_cnt, v_cnt;
  logic       active_c, hs_c, vs_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic       active0, hs0, vs0;
  logic       active1, hs1, vs1, pix1;
  logic       hit1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == 10'd799) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == 10'd524) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Syncs are carried as active-low levels through the pipeline.
  always_comb begin
    active_c = (h_cnt < 10'd640) && (v_cnt < 10'd480);
    hs_c     = !((h_cnt >= 10'd656) && (h_cnt <= 10'd751));
    vs_c     = !((v_cnt >= 10'd490) && (v_cnt <= 10'd491));
    addr_c   = ADDR_WIDTH'(h_cnt) + (ADDR_WIDTH'(v_cnt) << 9) + (ADDR_WIDTH'(v_cnt) << 7);
  end

`ifdef SCARY_CURSOR_EN
  logic [9:0] x0, y0;
  logic [9:0] sx0;
  logic [8:0] sy0;
  logic       hit_c;

  // Unwrapped compares clip the square at the right/bottom edges.
  always_comb begin
    hit_c = ({1'b0, x0} >= {1'b0, sx0}) &&
            ({1'b0, x0} <  ({1'b0, sx0} + 11'(CURSOR_SIZE))) &&
            (y0 >= {1'b0, sy0}) &&
            (y0 <  ({1'b0, sy0} + 10'(CURSOR_SIZE)));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x0   <= '0;
      y0   <= '0;
      sx0  <= '0;
      sy0  <= '0;
      hit1 <= 1'b0;
    end else if (pix_en) begin
      x0   <= h_cnt;
      y0   <= v_cnt;
      sx0  <= scary_x;
      sy0  <= scary_y;
      hit1 <= hit_c;
    end
  end
`else
  logic unused_scary;
  assign unused_scary = ^{scary_x, scary_y};
  assign hit1 = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      read_addr <= '0;
      active0   <= 1'b0;
      hs0       <= 1'b1;
      vs0       <= 1'b1;
      active1   <= 1'b0;
      hs1       <= 1'b1;
      vs1       <= 1'b1;
      pix1      <= 1'b0;
      hSync     <= 1'b1;
      vSync     <= 1'b1;
      {VGA_R, VGA_G, VGA_B} <= 12'h000;
    end else if (pix_en) begin
      read_addr <= active_c ? addr_c : '0;
      active0   <= active_c;
      hs0       <= hs_c;
      vs0       <= vs_c;
      // RAM answers one clock after read_addr; pix_en spacing guarantees it is settled here.
      pix1      <= read_data;
      active1   <= active0;
      hs1       <= hs0;
      vs1       <= vs0;
      hSync     <= hs1;
      vSync     <= vs1;
      if (!active1)
        {VGA_R, VGA_G, VGA_B} <= 12'h000;
      else if (hit1)
        {VGA_R, VGA_G, VGA_B} <= CURSOR_RGB;
      else
        {VGA_R, VGA_G, VGA_B} <= pix1 ? FG_RGB : BG_RGB;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      frame_end <= 1'b0;
    else
      frame_end <= pix_en && (h_cnt == 10'd639) && (v_cnt == 10'd479);
  end

endmodule
